// File: rtl/axis_sync_fifo.sv
//------------------------------------------------------------------------------
// Module   : axis_sync_fifo
// Brief    : Single-clock AXI-Stream FIFO, first-word-fall-through output,
//            registered fill level. Optional sticky overflow flag enabled by
//            defining AXIS_SYNC_FIFO_OVERFLOW_FLAG_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axis_sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_LEN   = 16,
    parameter int USER_WIDTH = 0
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic [DATA_WIDTH-1:0]                         s_axis_in_tdata,
    input  logic [((USER_WIDTH > 0) ? USER_WIDTH : 1)-1:0] s_axis_in_tuser,
    input  logic                                          s_axis_in_tlast,
    input  logic                                          s_axis_in_tvalid,
    output logic                                          s_axis_in_tready,
    output logic [DATA_WIDTH-1:0]                         m_axis_out_tdata,
    output logic [((USER_WIDTH > 0) ? USER_WIDTH : 1)-1:0] m_axis_out_tuser,
    output logic                                          m_axis_out_tlast,
    output logic                                          m_axis_out_tvalid,
    input  logic                                          m_axis_out_tready,
`ifdef AXIS_SYNC_FIFO_OVERFLOW_FLAG_EN
    output logic [$clog2(FIFO_LEN):0]                     m_axis_out_level,
    output logic                                          overflow_o
`else
    output logic [$clog2(FIFO_LEN):0]                     m_axis_out_level
`endif
);

    localparam int c_user_w  = (USER_WIDTH > 0) ? USER_WIDTH : 1;
    localparam int c_ptr_w   = $clog2(FIFO_LEN);
    localparam int c_lvl_w   = c_ptr_w + 1;
    localparam int c_entry_w = DATA_WIDTH + c_user_w + 1;
    localparam logic [c_lvl_w-1:0] c_full = c_lvl_w'(FIFO_LEN);

    // Entry layout: {tdata, tuser, tlast}
    logic [c_entry_w-1:0] r_mem [FIFO_LEN];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_lvl_w-1:0]   r_level;
    logic [c_entry_w-1:0] w_head;
    logic                 w_accept;
    logic                 w_pop;

    assign s_axis_in_tready  = (r_level != c_full);
    assign m_axis_out_tvalid = (r_level != '0);
    assign m_axis_out_level  = r_level;

    // Reset cycle must not commit a write even though the pointers are cleared.
    assign w_accept = s_axis_in_tvalid && s_axis_in_tready && !reset_i;
    assign w_pop    = m_axis_out_tvalid && m_axis_out_tready;

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {s_axis_in_tdata, s_axis_in_tuser, s_axis_in_tlast};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_head           = r_mem[r_rd_ptr];
    assign m_axis_out_tdata = w_head[c_entry_w-1 -: DATA_WIDTH];
    assign m_axis_out_tlast = w_head[0];

    generate
        if (USER_WIDTH > 0) begin : g_user
            assign m_axis_out_tuser = w_head[c_user_w:1];
        end else begin : g_no_user
            // Sideband bit is still stored but never presented.
            logic w_unused_user;
            assign w_unused_user    = w_head[1];
            assign m_axis_out_tuser = '0;
        end
    endgenerate

`ifdef AXIS_SYNC_FIFO_OVERFLOW_FLAG_EN
    logic r_overflow;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_overflow <= 1'b0;
        end else if (s_axis_in_tvalid && (r_level == c_full)) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_o = r_overflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_sync_fifo.sv
//------------------------------------------------------------------------------
// Module   : tb_axis_sync_fifo
// Brief    : Self-checking bench for axis_sync_fifo (16x16, 4-bit tuser) with a
//            queue-based reference model and directed scenarios.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_sync_fifo;

    localparam int DW  = 16;
    localparam int LEN = 16;
    localparam int UW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [UW-1:0] s_tuser = '0;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [4:0]    m_level;
    logic          ovf;

    axis_sync_fifo #(.DATA_WIDTH(DW), .FIFO_LEN(LEN), .USER_WIDTH(UW)) dut (
        .clk_i             (clk),
        .reset_i           (rst),
        .s_axis_in_tdata   (s_tdata),
        .s_axis_in_tuser   (s_tuser),
        .s_axis_in_tlast   (s_tlast),
        .s_axis_in_tvalid  (s_tvalid),
        .s_axis_in_tready  (s_tready),
        .m_axis_out_tdata  (m_tdata),
        .m_axis_out_tuser  (m_tuser),
        .m_axis_out_tlast  (m_tlast),
        .m_axis_out_tvalid (m_tvalid),
        .m_axis_out_tready (m_tready),
`ifdef AXIS_SYNC_FIFO_OVERFLOW_FLAG_EN
        .m_axis_out_level  (m_level),
        .overflow_o        (ovf)
`else
        .m_axis_out_level  (m_level)
`endif
    );

`ifndef AXIS_SYNC_FIFO_OVERFLOW_FLAG_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: a queue of {data,user,last}, updated on each rising edge.
    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
    } entry_t;
    entry_t q[$];
    bit     m_ovf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            bit acc;
            bit pop;
            acc = s_tvalid && (q.size() < LEN);
            pop = m_tready && (q.size() > 0);
            if (s_tvalid && q.size() == LEN) m_ovf = 1'b1;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{d: s_tdata, u: s_tuser, l: s_tlast});
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            check("cyc_level", 32'(m_level), 32'(q.size()));
            check("cyc_tvalid", 32'(m_tvalid), 32'(q.size() != 0));
            check("cyc_tready", 32'(s_tready), 32'(q.size() != LEN));
`ifdef AXIS_SYNC_FIFO_OVERFLOW_FLAG_EN
            check("cyc_ovf", 32'(ovf), 32'(m_ovf));
`endif
            if (q.size() != 0) begin
                check("cyc_head", {15'd0, m_tdata, m_tuser, m_tlast},
                      {15'd0, q[0].d, q[0].u, q[0].l});
            end
        end
    end

    task automatic cycle(input bit v, input logic [DW-1:0] d, input logic [UW-1:0] u,
                         input bit l, input bit r);
        s_tvalid = v;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        m_tready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        for (int k = 0; k < LEN + 2; k++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        m_tready = 1'b0;
    endtask

    initial begin
        int wr_idx;
        int rd_idx;
        int budget;
        bit v;
        bit r;

        rst = 1'b1;
        repeat (2) cycle(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        model_en = 1'b1;
        check("rst_level", 32'(m_level), 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);

        // Single write, read side stalled
        cycle(1'b1, 16'h1234, 4'h5, 1'b1, 1'b0);
        s_tvalid = 1'b0;
        check("single_tvalid", 32'(m_tvalid), 32'd1);
        check("single_tdata", 32'(m_tdata), 32'h1234);
        check("single_tuser", 32'(m_tuser), 32'h5);
        check("single_tlast", 32'(m_tlast), 32'd1);
        check("single_level", 32'(m_level), 32'd1);
        drain_all();

        // Fill past capacity, then drain
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, DW'(i), UW'(i), (i == 19), 1'b0);
            if (i == 15) begin
                check("fill_level16", 32'(m_level), 32'd16);
                check("fill_tready0", 32'(s_tready), 32'd0);
            end
        end
        s_tvalid = 1'b0;
        check("fill_level_end", 32'(m_level), 32'd16);
`ifdef AXIS_SYNC_FIFO_OVERFLOW_FLAG_EN
        check("fill_ovf", 32'(ovf), 32'd1);
`endif
        for (int k = 0; k < 16; k++) begin
            check("drain_tvalid", 32'(m_tvalid), 32'd1);
            check("drain_data", 32'(m_tdata), 32'(k));
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
        end
        check("drain_empty", 32'(m_tvalid), 32'd0);
        m_tready = 1'b0;

        // Streaming with one prefilled word
        cycle(1'b1, 16'hAAAA, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            check("stream_data", 32'(m_tdata), (i == 0) ? 32'hAAAA : 32'h100 + 32'(i - 1));
            cycle(1'b1, 16'h100 + DW'(i), UW'(i), 1'b0, 1'b1);
            check("stream_level", 32'(m_level), 32'd1);
        end
        s_tvalid = 1'b0;
        check("stream_last", 32'(m_tdata), 32'h100 + 32'd99);
        drain_all();

        // Full boundary: write and pop together while full
        for (int i = 0; i < 16; i++) cycle(1'b1, 16'h200 + DW'(i), '0, 1'b0, 1'b0);
        check("bnd_full", 32'(m_level), 32'd16);
        cycle(1'b1, 16'hBEEF, 4'hF, 1'b1, 1'b1);
        s_tvalid = 1'b0;
        check("bnd_level15", 32'(m_level), 32'd15);
        for (int k = 0; k < 15; k++) begin
            check("bnd_data", 32'(m_tdata), 32'h201 + 32'(k));
            cycle(1'b0, '0, '0, 1'b0, 1'b1);
        end
        check("bnd_empty", 32'(m_tvalid), 32'd0);
        m_tready = 1'b0;

        // Refill past full so a set flag exists to be cleared, then reset at level 7
        for (int i = 0; i < 17; i++) cycle(1'b1, 16'h500 + DW'(i), '0, 1'b0, 1'b0);
        s_tvalid = 1'b0;
        drain_all();
        for (int i = 0; i < 7; i++) cycle(1'b1, 16'h400 + DW'(i), '0, 1'b0, 1'b0);
        check("mid_level7", 32'(m_level), 32'd7);
        rst = 1'b1;
        cycle(1'b1, 16'h0999, 4'h9, 1'b0, 1'b0);
        rst = 1'b0;
        s_tvalid = 1'b0;
        check("mid_rst_level", 32'(m_level), 32'd0);
        check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_tready", 32'(s_tready), 32'd1);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        cycle(1'b1, 16'h0042, 4'h2, 1'b1, 1'b0);
        s_tvalid = 1'b0;
        check("mid_head", 32'(m_tdata), 32'h0042);
        check("mid_head_level", 32'(m_level), 32'd1);
        drain_all();

        // Pointer wrap with random gaps on both sides
        wr_idx = 0;
        rd_idx = 0;
        budget = 2000;
        while (rd_idx < 3 * LEN && budget > 0) begin
            v = (wr_idx < 3 * LEN) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 2) != 0);
            if (m_tvalid && r) begin
                check("wrap_data", 32'(m_tdata), 32'h300 + 32'(rd_idx));
                rd_idx++;
            end
            if (v && s_tready) wr_idx++;
            cycle(v, 16'h300 + DW'(wr_idx - ((v && s_tready) ? 1 : 0)), UW'(wr_idx), 1'b0, r);
            if (m_level > 5'd16) check("wrap_level_bound", 32'(m_level), 32'd16);
            budget--;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        check("wrap_count", 32'(rd_idx), 32'(3 * LEN));
        check("wrap_empty", 32'(m_level), 32'd0);

        model_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_sync_fifo.md
AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning tdata width in bits (>=1).
REQ-002 The block SHALL have parameter FIFO_LEN, default 16, meaning depth in entries (power of two, >=2).
REQ-003 The block SHALL have parameter USER_WIDTH, default 0, meaning tuser width; when 0, the tuser ports are 1 bit, the input is ignored and the output is driven 0.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port s_axis_in_tdata, input, DATA_WIDTH bits: write data.
REQ-007 The block SHALL have port s_axis_in_tuser, input, max(USER_WIDTH,1) bits: write sideband.
REQ-008 The block SHALL have port s_axis_in_tlast, input, 1 bit: write end-of-packet marker.
REQ-009 The block SHALL have port s_axis_in_tvalid, input, 1 bit: write request.
REQ-010 The block SHALL have port s_axis_in_tready, output, 1 bit: high when not full.
REQ-011 The block SHALL have port m_axis_out_tdata, output, DATA_WIDTH bits: head-entry data.
REQ-012 The block SHALL have port m_axis_out_tuser, output, max(USER_WIDTH,1) bits: head-entry sideband.
REQ-013 The block SHALL have port m_axis_out_tlast, output, 1 bit: head-entry last marker.
REQ-014 The block SHALL have port m_axis_out_tvalid, output, 1 bit: high when not empty.
REQ-015 The block SHALL have port m_axis_out_tready, input, 1 bit: read/pop request.
REQ-016 The block SHALL have port m_axis_out_level, output, $clog2(FIFO_LEN)+1 bits: current number of stored entries.

Function
REQ-017 Write accept SHALL be s_axis_in_tvalid && s_axis_in_tready; the accepted entry is {tdata, tuser, tlast}.
REQ-018 Read pop SHALL be m_axis_out_tvalid && m_axis_out_tready.
REQ-019 Writes offered while full SHALL be silently dropped, with no corruption; upstream is not required to honour tready.
REQ-020 Output SHALL be first-word-fall-through: the m_axis_out_* data fields show the oldest entry combinationally from storage whenever tvalid=1.
REQ-021 When tvalid=0, the data fields SHALL be don't-care, and a tready asserted while empty SHALL have no effect.
REQ-022 Write-to-output latency SHALL be 1 cycle: an entry accepted at edge N is visible with tvalid=1 after edge N; there is no same-cycle bypass when empty.
REQ-023 Order SHALL be strict FIFO; read and write pointers SHALL each be $clog2(FIFO_LEN) bits and wrap modulo FIFO_LEN.
REQ-024 Level SHALL be registered: +1 on accept-only, -1 on pop-only, and unchanged on simultaneous accept and pop.
REQ-025 s_axis_in_tready SHALL equal (level != FIFO_LEN) and m_axis_out_tvalid SHALL equal (level != 0), both derived from the registered level.
REQ-026 When full with a simultaneous write and pop in the same cycle, the write SHALL be rejected (tready=0) and the pop SHALL proceed, giving level FIFO_LEN-1.
REQ-027 When level is 1 with a simultaneous accept and pop, the old head SHALL be popped, the new entry SHALL become head, and level SHALL stay 1.
REQ-028 Full capacity SHALL be exactly FIFO_LEN entries.

Reset
REQ-029 With reset_i=1 at a clock edge, the pointers and level SHALL go to 0, giving m_axis_out_tvalid=0, s_axis_in_tready=1 and m_axis_out_level=0.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries, and inputs during reset SHALL be ignored (no write accepted in the reset cycle).
REQ-032 The overflow flag, when compiled in, SHALL reset to 0.

Configuration
REQ-033 The macro AXIS_SYNC_FIFO_OVERFLOW_FLAG_EN SHALL control an overflow flag.
REQ-034 When AXIS_SYNC_FIFO_OVERFLOW_FLAG_EN is defined, the block SHALL add output overflow_o (1 bit) that is sticky: it sets on the cycle after any s_axis_in_tvalid=1 with level==FIFO_LEN, and clears only on reset.
REQ-035 When AXIS_SYNC_FIFO_OVERFLOW_FLAG_EN is undefined, the overflow_o port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (DATA_WIDTH=16, FIFO_LEN=16, USER_WIDTH=4)
REQ-036 Bench SHALL cover single write: write 0x1234/user 0x5/last 1 into an empty FIFO with tready held 0 -> one cycle later tvalid=1, tdata=0x1234, tuser=0x5, tlast=1, level=1.
REQ-037 Bench SHALL cover fill and overflow: write 0..19 with tvalid held and no reads -> level stops at 16, tready=0 after the 16th write, values 16..19 dropped, overflow_o=1 if the flag is enabled; then draining with tready=1 yields 0..15 in order and then tvalid=0.
REQ-038 Bench SHALL cover streaming: write and read continuously every cycle for 100 cycles after a single prefill word 0xAAAA -> level stays 1, output sequence is 0xAAAA followed by the written values in order.
REQ-039 Bench SHALL cover full-boundary simultaneous access: with level=16, apply write 0xBEEF and pop together -> 0xBEEF not stored, level=15.
REQ-040 Bench SHALL cover reset mid-operation: with level=7, assert reset_i for one cycle -> level=0, tvalid=0, tready=1, overflow_o=0, and a subsequent write of 0x0042 appears at the head.
REQ-041 Bench SHALL cover pointer wrap: run 3*FIFO_LEN write/read pairs with random tvalid/tready gaps -> output matches the write order exactly, and level never exceeds 16 or goes negative.
